cpu_axi_bridge: RTL and testbench

//  Converts the core's inst/data sram-like request ports into one AXI3 master; sits between the core and the SoC AXI interconnect.

---
 rtl/cpu_axi_bridge_pkg.sv | 35 +++
 rtl/axi_rd_arb.sv | 97 +++++++++
 rtl/cpu_axi_bridge.sv | 146 ++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI bridge: FSM state encodings, the
// default AXI IDs for fetch and load reads, sram size codes and a debug
// view of both FSMs.
package cpu_axi_bridge_pkg;

  // Read FSM states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_R    = 2'd2;

  // Write FSM states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_B    = 2'd2;

  // Default read IDs
  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  // sram size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [1:0] rd_state;
    logic [1:0] wr_state;
  } dbg_state_t;

  // AXI size field from the sram size code.
  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/axi_rd_arb.sv
// Read arbitration and read FSM (R_IDLE -> R_AR -> R_R -> R_IDLE).
// A pending load (already hazard-gated by the caller) beats a fetch.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   inst_req/inst_addr                 fetch request
//   inst_addr_ok/inst_data_ok/rdata    fetch accept, fetch data pulse, data
//   load_req/load_addr/load_size       load request (store hazard resolved)
//   load_addr_ok                       load accepted this cycle
//   load_hit                           R beat for a load accepted this cycle
//   arid/araddr/arsize/arvalid/arready AR channel
//   rid/rdata/rvalid/rready            R channel
//   state                              read FSM state (debug)
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds with a stable payload until then.
module axi_rd_arb
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [1:0]  load_size,
  output logic        load_addr_ok,
  output logic        load_hit,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [1:0]  state
);

  logic idle;

  // Nothing is accepted while reset is asserted.
  assign idle         = (state == R_IDLE) && !reset;
  assign load_addr_ok = idle && load_req;
  assign inst_addr_ok = idle && inst_req && !load_req;

  assign arvalid  = (state == R_AR);
  assign rready   = (state == R_R);
  assign load_hit = (state == R_R) && rvalid && (rid == DATA_ID);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= R_IDLE;
      arid         <= 4'd0;
      araddr       <= 32'd0;
      arsize       <= 3'd0;
      inst_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
    end else begin
      inst_data_ok <= 1'b0;
      case (state)
        R_IDLE: begin
          if (load_addr_ok) begin
            arid   <= DATA_ID;
            araddr <= load_addr;
            arsize <= axi_size(load_size);
            state  <= R_AR;
          end else if (inst_addr_ok) begin
            arid   <= INST_ID;
            araddr <= inst_addr;
            arsize <= axi_size(SIZE_WORD);
            state  <= R_AR;
          end
        end
        R_AR: if (arready) state <= R_R;
        R_R: begin
          if (rvalid) begin
            state <= R_IDLE;
            // Fetch data lands in its output register on the same edge
            // that raises data_ok, so it holds until the next fetch pulse.
            if (rid == INST_ID) begin
              inst_data_ok <= 1'b1;
              inst_rdata   <= rdata;
            end
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's inst/data sram-like ports onto one AXI3 master.
// Reads (fetch and load) go through axi_rd_arb; stores run the write FSM
// below (W_IDLE -> W_REQ -> W_B -> W_IDLE). One read and one write may be
// in flight together; a load is never accepted while a store is pending.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inst_sram_*                fetch port (read only)
//   data_sram_*                load/store port
//   ar*/r*/aw*/w*/b*           AXI3 master channels
//   dbg_state                  read and write FSM states
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds with a stable payload until then.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output dbg_state_t  dbg_state
);

  logic [1:0]  r_state, w_state;
  logic        load_req, load_addr_ok, load_hit, store_ok;
  logic        aw_left, w_left, wr_done, rd_avail, rd_deliver;
  logic        rd_pend;
  logic [31:0] rd_buf;

  // RAW hazard: a load waits until no store is pending.
  assign load_req = data_sram_req && !data_sram_wr && (w_state == W_IDLE);
  assign store_ok = data_sram_req && data_sram_wr && (w_state == W_IDLE) && !reset;
  assign data_sram_addr_ok = store_ok || load_addr_ok;

  axi_rd_arb #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) u_rd (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_sram_req),
    .inst_addr    (inst_sram_addr),
    .inst_addr_ok (inst_sram_addr_ok),
    .inst_data_ok (inst_sram_data_ok),
    .inst_rdata   (inst_sram_rdata),
    .load_req     (load_req),
    .load_addr    (data_sram_addr),
    .load_size    (data_sram_size),
    .load_addr_ok (load_addr_ok),
    .load_hit     (load_hit),
    .arid         (arid),
    .araddr       (araddr),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rready       (rready),
    .state        (r_state)
  );

  assign bready    = (w_state == W_B);
  assign aw_left   = awvalid && !awready;
  assign w_left    = wvalid && !wready;
  assign dbg_state = '{rd_state: r_state, wr_state: w_state};

  // Data port completion: a store's B beat wins; a load that finishes in
  // the same cycle is parked in rd_buf and reported one cycle later.
  assign wr_done    = (w_state == W_B) && bvalid;
  assign rd_avail   = load_hit || rd_pend;
  assign rd_deliver = rd_avail && !wr_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state           <= W_IDLE;
      awaddr            <= 32'd0;
      awsize            <= 3'd0;
      awvalid           <= 1'b0;
      wdata             <= 32'd0;
      wstrb             <= 4'd0;
      wvalid            <= 1'b0;
      rd_pend           <= 1'b0;
      rd_buf            <= 32'd0;
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= 32'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (store_ok) begin
            awaddr  <= data_sram_addr;
            awsize  <= axi_size(data_sram_size);
            wdata   <= data_sram_wdata;
            wstrb   <= data_sram_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            w_state <= W_REQ;
          end
        end
        W_REQ: begin
          awvalid <= aw_left;
          wvalid  <= w_left;
          if (!aw_left && !w_left) w_state <= W_B;
        end
        W_B: if (bvalid) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase

      if (load_hit) rd_buf <= rdata;
      rd_pend           <= rd_avail && wr_done;
      data_sram_data_ok <= wr_done || rd_deliver;
      if (rd_deliver) data_sram_rdata <= rd_pend ? rd_buf : rdata;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge. Inputs change and outputs are sampled
// on the falling clock edge; the bench acts as the AXI slave.
module tb_cpu_axi_bridge;
  import cpu_axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  dbg_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  logic [31:0] slave_mem;

  // clock/reset block
  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // Count AW and W handshakes seen on the bus.
  always @(posedge clk) begin
    if (!reset && awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (!reset && wvalid && wready) w_cnt <= w_cnt + 1;
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Every valid/ready/ok output low and every payload register zero.
  task automatic check_quiet(input string tag);
    chk1({tag, "_arvalid"}, arvalid, 1'b0);
    chk1({tag, "_rready"}, rready, 1'b0);
    chk1({tag, "_awvalid"}, awvalid, 1'b0);
    chk1({tag, "_wvalid"}, wvalid, 1'b0);
    chk1({tag, "_bready"}, bready, 1'b0);
    chk1({tag, "_inst_addr_ok"}, inst_sram_addr_ok, 1'b0);
    chk1({tag, "_inst_data_ok"}, inst_sram_data_ok, 1'b0);
    chk1({tag, "_data_addr_ok"}, data_sram_addr_ok, 1'b0);
    chk1({tag, "_data_data_ok"}, data_sram_data_ok, 1'b0);
    chk32({tag, "_araddr"}, araddr, 32'd0);
    chk32({tag, "_arid"}, 32'(arid), 32'd0);
    chk32({tag, "_awaddr"}, awaddr, 32'd0);
    chk32({tag, "_wdata"}, wdata, 32'd0);
    chk32({tag, "_inst_rdata"}, inst_sram_rdata, 32'd0);
    chk32({tag, "_data_rdata"}, data_sram_rdata, 32'd0);
    chk32({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Slave side of one read: wait (bounded) for arvalid, check the AR
  // payload, accept it, then return one R beat. Returns on the falling
  // edge right after the R handshake.
  task automatic do_read(input string tag, input logic [3:0] eid,
                         input logic [31:0] eaddr, input logic [31:0] rd);
    int n;
    n = 0;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_arvalid"}, arvalid, 1'b1);
    if (!arvalid) return;
    chk32({tag, "_arid"}, 32'(arid), 32'(eid));
    chk32({tag, "_araddr"}, araddr, eaddr);
    chk32({tag, "_arsize"}, 32'(arsize), 32'd2);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk1({tag, "_rready"}, rready, 1'b1);
    chk1({tag, "_arvalid_drop"}, arvalid, 1'b0);
    rvalid = 1'b1;
    rid    = eid;
    rdata  = rd;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_addr = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
    data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    slave_mem = 32'd0;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    // Step 1: single fetch
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000;
    #1;
    chk1("f1_addr_ok", inst_sram_addr_ok, 1'b1);
    chk1("f1_data_addr_ok", data_sram_addr_ok, 1'b0);
    @(negedge clk);
    inst_sram_req = 1'b0;
    do_read("f1", 4'd0, 32'h1c00_0000, 32'h0280_0c0c);
    chk1("f1_data_ok", inst_sram_data_ok, 1'b1);
    chk32("f1_rdata", inst_sram_rdata, 32'h0280_0c0c);
    chk1("f1_no_data_port_ok", data_sram_data_ok, 1'b0);
    @(negedge clk);
    chk1("f1_pulse_end", inst_sram_data_ok, 1'b0);
    chk32("f1_rdata_hold", inst_sram_rdata, 32'h0280_0c0c);

    // Step 2: fetch and load in the same cycle, load wins
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0004;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h8; data_sram_size = 2'd2;
    #1;
    chk1("arb_data_addr_ok", data_sram_addr_ok, 1'b1);
    chk1("arb_inst_blocked", inst_sram_addr_ok, 1'b0);
    @(negedge clk);
    data_sram_req = 1'b0;
    #1;
    chk1("arb_inst_wait", inst_sram_addr_ok, 1'b0);
    do_read("ld8", 4'd1, 32'h8, 32'haaaa_5555);
    #1;
    chk1("ld8_data_ok", data_sram_data_ok, 1'b1);
    chk32("ld8_rdata", data_sram_rdata, 32'haaaa_5555);
    chk1("ld8_no_inst_ok", inst_sram_data_ok, 1'b0);
    chk1("arb_inst_now_ok", inst_sram_addr_ok, 1'b1);
    @(negedge clk);
    inst_sram_req = 1'b0;
    do_read("f2", 4'd0, 32'h1c00_0004, 32'h1111_2222);
    chk1("f2_data_ok", inst_sram_data_ok, 1'b1);
    chk32("f2_rdata", inst_sram_rdata, 32'h1111_2222);
    chk32("f2_data_rdata_hold", data_sram_rdata, 32'haaaa_5555);

    // Step 3: halfword store, AW accepted 3 cycles before W
    @(negedge clk);
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h10;
    data_sram_size = 2'd1; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h1234;
    #1;
    chk1("st10_addr_ok", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    data_sram_req = 1'b0;
    chk1("st10_awvalid", awvalid, 1'b1);
    chk1("st10_wvalid", wvalid, 1'b1);
    chk32("st10_awaddr", awaddr, 32'h10);
    chk32("st10_awsize", 32'(awsize), 32'd1);
    chk32("st10_wstrb", 32'(wstrb), 32'b0011);
    chk32("st10_wdata", wdata, 32'h1234);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk1("st10_aw_drop", awvalid, 1'b0);
    chk1("st10_w_hold1", wvalid, 1'b1);
    chk1("st10_no_bready", bready, 1'b0);
    @(negedge clk);
    chk1("st10_w_hold2", wvalid, 1'b1);
    @(negedge clk);
    chk1("st10_w_hold3", wvalid, 1'b1);
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    chk1("st10_w_drop", wvalid, 1'b0);
    chk1("st10_bready", bready, 1'b1);
    chk32("st10_aw_count", 32'(aw_cnt), 32'd1);
    chk32("st10_w_count", 32'(w_cnt), 32'd1);
    chk1("st10_no_early_ok", data_sram_data_ok, 1'b0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    chk1("st10_data_ok", data_sram_data_ok, 1'b1);
    chk1("st10_bready_drop", bready, 1'b0);
    @(negedge clk);
    chk1("st10_pulse_end", data_sram_data_ok, 1'b0);

    // Step 4: store 0x20 then load 0x20 in the next cycle
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h20;
    data_sram_size = 2'd2; data_sram_wstrb = 4'hf; data_sram_wdata = 32'hcafe_f00d;
    #1;
    chk1("st20_addr_ok", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    data_sram_wr = 1'b0;
    #1;
    chk1("raw_block_wreq", data_sram_addr_ok, 1'b0);
    chk1("raw_no_ar", arvalid, 1'b0);
    slave_mem = wdata;
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    #1;
    chk1("raw_block_wb", data_sram_addr_ok, 1'b0);
    chk1("st20_bready", bready, 1'b1);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    chk1("st20_data_ok", data_sram_data_ok, 1'b1);
    chk1("raw_load_accept", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    data_sram_req = 1'b0;
    do_read("ld20", 4'd1, 32'h20, slave_mem);
    chk1("ld20_data_ok", data_sram_data_ok, 1'b1);
    chk32("ld20_rdata", data_sram_rdata, 32'hcafe_f00d);

    // Step 5: load and store complete on the same edge
    @(negedge clk);
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h30;
    #1;
    chk1("col_ld_addr_ok", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    data_sram_wr = 1'b1; data_sram_addr = 32'h40; data_sram_wdata = 32'h5;
    #1;
    chk1("col_st_addr_ok", data_sram_addr_ok, 1'b1);
    chk1("col_arvalid", arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    data_sram_req = 1'b0; arready = 1'b0;
    chk1("col_rready", rready, 1'b1);
    chk1("col_awvalid", awvalid, 1'b1);
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk1("col_bready", bready, 1'b1);
    bvalid = 1'b1; rvalid = 1'b1; rid = 4'd1; rdata = 32'h77;
    @(negedge clk);
    bvalid = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    chk1("col_wr_ok", data_sram_data_ok, 1'b1);
    chk32("col_rdata_old", data_sram_rdata, 32'hcafe_f00d);
    @(negedge clk);
    chk1("col_rd_ok", data_sram_data_ok, 1'b1);
    chk32("col_rdata_new", data_sram_rdata, 32'h77);
    @(negedge clk);
    chk1("col_pulse_end", data_sram_data_ok, 1'b0);

    // Step 6: AR stall for 5 cycles, then reset while in R_R
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0100;
    #1;
    chk1("stall_addr_ok", inst_sram_addr_ok, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("stall_arvalid", arvalid, 1'b1);
      chk32("stall_araddr", araddr, 32'h1c00_0100);
      chk32("stall_arid", 32'(arid), 32'd0);
      chk1("stall_no_addr_ok", inst_sram_addr_ok, 1'b0);
    end
    inst_sram_req = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk1("stall_rready", rready, 1'b1);
    chk32("stall_rd_state", 32'(dbg_state.rd_state), 32'(R_R));
    reset = 1'b1;
    @(negedge clk);
    check_quiet("rst_in_rr");
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
